// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester channels and the data-RAM port around dmem_port_arbiter.
// slave is the arbiter's view; master is the surrounding CPU, DMA and RAM.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic              owner;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_data, mem_wren,
        input  mem_q,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_data, mem_wren,
        output mem_q,
        input  owner, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single synchronous-read data RAM port between the CPU and a DMA/debug requester.
// Every access takes IDLE -> ISSUE -> CAPTURE -> DONE; CPU wins contests unless DMA has starved.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clockCPU,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);

    localparam int            SW         = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t            state, next_state;
    logic              grant_cpu, grant_dma;
    logic              mem_wren_c;

    logic [SW-1:0]     starve;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              owner_q;
    logic              cpu_ack_q, dma_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        grant_cpu  = 1'b0;
        grant_dma  = 1'b0;
        mem_wren_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req && !(bus.dma_req && starve == STARVE_MAX)) grant_cpu = 1'b1;
                else if (bus.dma_req)                                      grant_dma = 1'b1;
                if (grant_cpu || grant_dma) next_state = ISSUE;
            end
            ISSUE: begin
                mem_wren_c = lat_we;
                next_state = CAPTURE;
            end
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            starve      <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            owner_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (grant_cpu) begin
                lat_we    <= bus.cpu_we;
                lat_addr  <= bus.cpu_addr;
                lat_wdata <= bus.cpu_wdata;
                owner_q   <= 1'b0;
                // Only a contested CPU win pushes DMA closer to its forced turn.
                if (bus.dma_req && starve != STARVE_MAX) starve <= starve + 1'b1;
            end
            if (grant_dma) begin
                lat_we    <= bus.dma_we;
                lat_addr  <= bus.dma_addr;
                lat_wdata <= bus.dma_wdata;
                owner_q   <= 1'b1;
                starve    <= '0;
            end
            if (state == CAPTURE) begin
                if (owner_q) begin
                    dma_rdata_q <= bus.mem_q;
                    dma_ack_q   <= 1'b1;
                end else begin
                    cpu_rdata_q <= bus.mem_q;
                    cpu_ack_q   <= 1'b1;
                end
            end
            if (state == DONE) begin
                cpu_ack_q <= 1'b0;
                dma_ack_q <= 1'b0;
            end
        end
    end

    // mem_wren is decoded from state so an asynchronous reset kills a pending write at once.
    assign bus.mem_wren  = mem_wren_c;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_data  = lat_wdata;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-timeline model (grant at g, RAM sample at g+1, ack at g+3).
module tb_dmem_port_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic clockCPU = 1'b0;
    logic reset    = 1'b1;
    logic preload  = 1'b1;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clockCPU (clockCPU),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clockCPU = ~clockCPU;

    // Synchronous-read RAM, read-before-write on the same address.
    logic [DATA_W-1:0] ram [1024];
    always @(posedge clockCPU) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            ram[5] <= 32'hDEADBEEF;
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_q <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: one access is a 4-cycle timeline starting at its grant cycle.
    logic [DATA_W-1:0] ref_mem [1024];
    int                cyc;
    bit                active;
    int                grant_cyc;
    int                starve;
    req_t              cur;
    bit                m_owner;
    logic [DATA_W-1:0] m_cpu_rdata, m_dma_rdata, m_q;

    function automatic req_t mk(input logic r, input logic w, input int a, input logic [31:0] d);
        req_t t;
        t.req   = r;
        t.we    = w;
        t.addr  = ADDR_W'(a);
        t.wdata = d;
        return t;
    endfunction

    task automatic model_reset();
        active      = 0;
        starve      = 0;
        m_owner     = 0;
        cur         = '0;
        m_cpu_rdata = '0;
        m_dma_rdata = '0;
    endtask

    task automatic drive(input req_t c, input req_t d);
        bus.cpu_req   = c.req;
        bus.cpu_we    = c.we;
        bus.cpu_addr  = c.addr;
        bus.cpu_wdata = c.wdata;
        bus.dma_req   = d.req;
        bus.dma_we    = d.we;
        bus.dma_addr  = d.addr;
        bus.dma_wdata = d.wdata;
    endtask

    // One clock cycle: apply inputs, compare every output, then advance the model past the edge.
    task automatic step(input req_t c, input req_t d);
        int  p;
        bit  e_cack, e_dack, win_dma;
        @(negedge clockCPU);
        drive(c, d);
        #1;
        p      = active ? cyc - grant_cyc : 0;
        e_cack = active && p == 3 && !m_owner;
        e_dack = active && p == 3 &&  m_owner;
        check("busy",      32'(bus.busy),      32'(active));
        check("owner",     32'(bus.owner),     32'(m_owner));
        check("mem_wren",  32'(bus.mem_wren),  32'(active && p == 1 && cur.we));
        check("mem_addr",  32'(bus.mem_addr),  32'(cur.addr));
        check("mem_data",  bus.mem_data,       cur.wdata);
        check("cpu_ack",   32'(bus.cpu_ack),   32'(e_cack));
        check("dma_ack",   32'(bus.dma_ack),   32'(e_dack));
        check("cpu_rdata", bus.cpu_rdata,      m_cpu_rdata);
        check("dma_rdata", bus.dma_rdata,      m_dma_rdata);
        check("cpu_stall", 32'(bus.cpu_stall), 32'(c.req && !e_cack));
        if (!active) begin
            if (c.req || d.req) begin
                win_dma   = d.req && (!c.req || starve == MAX_WAIT);
                cur       = win_dma ? d : c;
                m_owner   = win_dma;
                starve    = win_dma ? 0 : (d.req ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : starve);
                active    = 1;
                grant_cyc = cyc;
            end
        end else if (p == 1) begin
            m_q = ref_mem[cur.addr];
            if (cur.we) ref_mem[cur.addr] = cur.wdata;
        end else if (p == 2) begin
            if (m_owner) m_dma_rdata = m_q;
            else         m_cpu_rdata = m_q;
        end else begin
            active = 0;
        end
        cyc++;
    endtask

    req_t none;
    req_t c_req, d_req;

    initial begin
        none = '0;
        drive(none, none);
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        ref_mem[5] = 32'hDEADBEEF;
        model_reset();
        cyc = 0;
        repeat (2) @(posedge clockCPU);
        @(negedge clockCPU);
        preload = 1'b0;
        reset   = 1'b0;

        // CPU read of 0x005; request dropped in DONE.
        for (int i = 0; i < 3; i++) step(mk(1, 0, 5, 0), none);
        step(none, none);
        check("cpu_rd_deadbeef", bus.cpu_rdata, 32'hDEADBEEF);
        repeat (2) step(none, none);

        // CPU write then DMA readback of 0x010.
        for (int i = 0; i < 4; i++) step(mk(i < 3, 1, 'h010, 32'h12345678), none);
        for (int i = 0; i < 4; i++) step(none, mk(i < 3, 0, 'h010, 0));
        check("dma_rd_12345678", bus.dma_rdata, 32'h12345678);

        // Sustained contest: four CPU wins, then DMA, then CPU again.
        for (int i = 0; i < 28; i++) step(mk(1, 0, i, 0), mk(1, 0, 'h010, 0));
        step(none, none);

        // DMA alone, back-to-back reads of 0x3FF, 0x000, 0x001.
        for (int i = 0; i < 12; i++) begin
            d_req = mk(1, 0, (i < 4) ? 'h3FF : (i < 8) ? 'h000 : 'h001, 0);
            step(none, d_req);
        end
        repeat (2) step(none, none);

        // Reset in ISSUE of a CPU write to 0x020: the write must never reach the RAM.
        step(mk(1, 1, 'h020, 32'hAAAAAAAA), none);
        @(negedge clockCPU);
        #1;
        check("issue_wren_pre", 32'(bus.mem_wren), 32'd1);
        reset = 1'b1;
        drive(none, none);
        #1;
        check("rst_wren", 32'(bus.mem_wren), 32'd0);
        check("rst_busy", 32'(bus.busy),     32'd0);
        check("rst_ack",  32'(bus.cpu_ack),  32'd0);
        model_reset();
        cyc++;
        @(posedge clockCPU);
        @(negedge clockCPU);
        reset = 1'b0;
        check("ram_20_kept", ram['h20], 32'h0);
        for (int i = 0; i < 4; i++) step(mk(i < 3, 1, 'h020, 32'hAAAAAAAA), none);
        for (int i = 0; i < 4; i++) step(mk(i < 3, 0, 'h020, 0), none);
        check("ram_20_rd", bus.cpu_rdata, 32'hAAAAAAAA);

        // DMA drops its request right after the grant, CPU waits behind it.
        step(none, mk(1, 0, 5, 0));
        for (int i = 0; i < 8; i++) step(mk(1, 0, 'h010, 0), none);
        step(none, none);

        // Random traffic over a small address window plus the top word.
        for (int i = 0; i < 600; i++) begin
            c_req = mk($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 9) == 0) ? 'h3FF : $urandom_range(0, 7), $urandom);
            d_req = mk($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 9) == 0) ? 'h3FF : $urandom_range(0, 7), $urandom);
            step(c_req, d_req);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single port of the data memory between two requesters: the multicycle CPU data access and a secondary DMA/debug requester (display readback, memory dump).
- Sits between the CPU memory mux and the data RAM.
- The data RAM has synchronous read: it samples address, data and wren on the clock edge, and q is valid the following cycle.
- Sequences each access through a fixed 4-state FSM. CPU has priority, with a starvation guard for the DMA side.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- DATA_W, 32, data width.
- MAX_WAIT, 4, number of consecutive contested CPU grants after which a pending DMA request wins. Must be ≥1.

Ports:
- clockCPU  in  1  clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack; the CPU control holds its state while high.
- dma_req, dma_we, dma_addr, dma_wdata  in  same widths as the CPU side  DMA request channel.
- dma_rdata  out  DATA_W  DMA read data; valid while dma_ack = 1.
- dma_ack  out  1  DMA completion pulse.
- mem_addr  out  ADDR_W  RAM address.
- mem_data  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data.
- owner  out  1  0 = CPU, 1 = DMA; requester owning the current or most recent access.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (asynchronous, active-high; clock clockCPU): forces the following, regardless of the clock.
  - state = IDLE; starve counter = 0; owner = 0.
  - cpu_ack = dma_ack = 0; cpu_rdata = dma_rdata = 0.
  - Latched request registers = 0.
  - mem_wren = 0 immediately, because mem_wren is decoded from state.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant CPU unless starve == MAX_WAIT, in which case grant DMA.
  - On grant: latch addr, we and wdata of the winner; owner <= winner; go to ISSUE.
- ISSUE:
  - mem_addr and mem_data come from the latches; mem_wren = latched we. The RAM samples at the end of this cycle.
  - Next state: CAPTURE.
- CAPTURE:
  - mem_wren = 0. mem_q is valid.
  - At the edge: the owner's rdata register <= mem_q (also done for writes, giving the RAM's q); the owner's ack <= 1.
  - Next state: DONE.
- DONE:
  - The owner's ack = 1 and rdata is stable.
  - No grant is made in this cycle; the requester drops req here.
  - At the edge: ack <= 0; next state IDLE.
- Latency: req sampled in IDLE at cycle 0 → ack high in cycle 3. Back-to-back accesses cost 4 cycles each. Requests are never merged.
- Outside ISSUE:
  - mem_addr and mem_data hold the latched values.
  - mem_wren = 0.
  - At most one mem_wren cycle occurs per grant.
- Starve counter (width clog2(MAX_WAIT+1)):
  - In IDLE, on a CPU grant while dma_req = 1: increment, saturating at MAX_WAIT.
  - On a DMA grant: clear to 0.
  - On a CPU grant with dma_req = 0: unchanged.
- Request inputs are don't-care outside IDLE. A requester dropping req mid-access does not abort the access; its ack still pulses.
- Rdata registers hold their value until the next completion of the same requester.
- Reset mid-access:
  - In ISSUE: the write is suppressed if reset is asserted before the sampling edge.
  - No ack is produced; after reset deasserts, the FSM restarts from IDLE.
- busy and owner are registered outputs or decoded from state; they have no combinational path from the req inputs.
- cpu_stall is the only combinational output driven from an input.

Test Plan:
- Reset, then CPU read: cpu_req = 1, cpu_we = 0, cpu_addr = 0x005, RAM[5] = 0xDEADBEEF → mem_wren never high; cpu_ack high exactly in cycle 3 with cpu_rdata = 0xDEADBEEF; cpu_stall high in cycles 0-2, low in cycle 3.
- CPU write then DMA read: CPU writes 0x12345678 to 0x010 → mem_wren high for exactly one cycle (cycle 1) with mem_addr = 0x010. Then DMA reads 0x010 → dma_ack high with dma_rdata = 0x12345678; owner = 1 during the DMA access.
- Simultaneous requests, MAX_WAIT = 4: cpu_req and dma_req both held high, CPU re-requesting after each ack → CPU granted 4 times; the 5th grant goes to DMA; starve counter then reads 0 and CPU wins the next contest.
- DMA alone, cpu_req = 0: 3 back-to-back reads of 0x3FF, 0x000, 0x001 → acks in cycles 3, 7 and 11; correct data each time; starve counter stays 0.
- Reset during ISSUE of a CPU write of 0xAAAAAAAA to 0x020 (RAM[0x20] = 0x0) → mem_wren drops immediately; RAM[0x20] remains 0x0; no cpu_ack; busy = 0. A repeated request after reset completes normally.
- DMA drops dma_req in cycle 1 of its access → dma_ack still pulses in cycle 3; the next IDLE cycle with cpu_req = 1 grants CPU.
